button_debounce: RTL

- Input-side companion to the LED display logic: conditions raw push-button inputs from the board into clean, single-clock events.
- Events are used to step, start or stop LED patterns.
- Per button: synchronizes the asynchronous pin, removes contact bounce with a stable-time counter, and produces a debounced level plus one-cycle press and release pulses.
- Sits between the top-level button pins and any LED pattern controller.

---
 rtl/button_debounce.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/button_debounce.sv
// Per-channel push-button conditioner: 2-flop sync, debounce FSM, press/release pulses.
// Ports: Clk, Rst (sync, active-high), BtnIn (raw pins) -> BtnLevel, BtnPress,
// BtnRelease, BtnRepeat. Optional auto-repeat enabled by macro BTN_REPEAT_EN.
module button_debounce #(
  parameter int NUM_BTN         = 6,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [NUM_BTN-1:0] BtnIn,
  output logic [NUM_BTN-1:0] BtnLevel,
  output logic [NUM_BTN-1:0] BtnPress,
  output logic [NUM_BTN-1:0] BtnRelease,
  output logic [NUM_BTN-1:0] BtnRepeat
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic RAW_REL = (ACTIVE_LOW != 0);

  localparam logic [1:0] S_REL = 2'd0;
  localparam logic [1:0] S_DBP = 2'd1;
  localparam logic [1:0] S_PRS = 2'd2;
  localparam logic [1:0] S_DBR = 2'd3;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rep
    $error("REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    logic          s1_q, s2_q, s;
    logic [1:0]    st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic          prs_q, prs_d;
    logic          rel_q, rel_d;

    // Sync flops hold the raw pin value; reset loads the raw "released" level.
    assign s = s2_q ^ RAW_REL;

    always_ff @(posedge Clk) begin
      if (Rst) begin
        s1_q  <= RAW_REL;
        s2_q  <= RAW_REL;
        st_q  <= S_REL;
        cnt_q <= '0;
        lvl_q <= 1'b0;
        prs_q <= 1'b0;
        rel_q <= 1'b0;
      end else begin
        s1_q  <= BtnIn[g];
        s2_q  <= s1_q;
        st_q  <= st_d;
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
        prs_q <= prs_d;
        rel_q <= rel_d;
      end
    end

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      prs_d = 1'b0;
      rel_d = 1'b0;
      unique case (st_q)
        S_REL: begin
          if (s) begin
            st_d  = S_DBP;
            cnt_d = '0;
          end
        end
        S_DBP: begin
          if (!s) begin
            st_d = S_REL;
          end else if (cnt_q == CNT_MAX) begin
            st_d  = S_PRS;
            lvl_d = 1'b1;
            prs_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_PRS: begin
          if (!s) begin
            st_d  = S_DBR;
            cnt_d = '0;
          end
        end
        default: begin
          if (s) begin
            st_d = S_PRS;
          end else if (cnt_q == CNT_MAX) begin
            st_d  = S_REL;
            lvl_d = 1'b0;
            rel_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end

    assign BtnLevel[g]   = lvl_q;
    assign BtnPress[g]   = prs_q;
    assign BtnRelease[g] = rel_q;

`ifdef BTN_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCW = $clog2(RMAX + 1);
    localparam logic [RCW-1:0] R_DLY = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] R_PER = RCW'(REPEAT_PERIOD - 1);

    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic           rph_q, rph_d;
    logic           rep_q, rep_d;
    logic           held;

    // DB_RELEASE keeps counting so a release glitch does not restart repeat.
    assign held = (st_q == S_PRS || st_q == S_DBR) && st_d != S_REL;

    always_ff @(posedge Clk) begin
      if (Rst) begin
        rcnt_q <= '0;
        rph_q  <= 1'b0;
        rep_q  <= 1'b0;
      end else begin
        rcnt_q <= rcnt_d;
        rph_q  <= rph_d;
        rep_q  <= rep_d;
      end
    end

    always_comb begin
      rcnt_d = '0;
      rph_d  = 1'b0;
      rep_d  = 1'b0;
      if (held) begin
        rph_d = rph_q;
        if (rcnt_q == (rph_q ? R_PER : R_DLY)) begin
          rep_d  = 1'b1;
          rph_d  = 1'b1;
          rcnt_d = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
    end

    assign BtnRepeat[g] = rep_q;
`else
    assign BtnRepeat[g] = 1'b0;
`endif
  end

endmodule
